// File: rtl/fifo_pkg.sv
// Shared constants and pause FSM encoding for the flow-controlled FIFO.
// Optional occupancy port in the top is enabled with FIFO_OCCUPANCY_EN.
package fifo_pkg;

  localparam int FIFO_BITNUMBER = 8;
  localparam int FIFO_LENGTH    = 8;
  localparam int ADDR_W         = $clog2(FIFO_LENGTH);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } pause_state_e;

endpackage

// File: rtl/fifo_mem.sv
// LENGTH x BITNUMBER register array: one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = FIFO_BITNUMBER,
  parameter int LENGTH    = FIFO_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(LENGTH)-1:0]  wr_addr,
  input  logic [BITNUMBER-1:0]       wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(LENGTH)-1:0]  rd_addr,
  output logic [BITNUMBER-1:0]       rd_data
);

  logic [BITNUMBER-1:0] mem [LENGTH];

  // NOTE: the array is deliberately not reset; stale words are never read
  // because the pointers and count are, and a reset would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A same-address write and read on one edge returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with hysteresis back-pressure (pause) and sticky error flag.
// Define FIFO_OCCUPANCY_EN to expose the registered count on port occupancy.
module fifo_flow_ctrl
  import fifo_pkg::*;
#(
  parameter int BITNUMBER = FIFO_BITNUMBER,
  parameter int LENGTH    = FIFO_LENGTH,
  parameter int HIGH_TH   = 6,
  parameter int LOW_TH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Fifo_wr,
  input  logic                  Fifo_rd,
  input  logic [BITNUMBER-1:0]  Fifo_Data_in,
  output logic [BITNUMBER-1:0]  Fifo_Data_out,
  output logic                  valid_out,
  output logic                  pause,
  output logic                  empty,
  output logic                  full,
  output logic                  error
`ifdef FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(LENGTH):0] occupancy
`endif
);

  localparam int AW = $clog2(LENGTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(LENGTH);
  localparam logic [AW:0] HIGH_C  = (AW+1)'(HIGH_TH);
  localparam logic [AW:0] LOW_C   = (AW+1)'(LOW_TH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, next_count;
  pause_state_e  state_q, state_d;
  logic          rd_ok, wr_ok, overflow, underflow;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign pause = (state_q == PAUSED);

  // A read frees a slot on the same edge, so a full FIFO still takes a write.
  assign rd_ok     = Fifo_rd && !empty;
  assign wr_ok     = Fifo_wr && (!full || rd_ok);
  assign overflow  = Fifo_wr && full && !rd_ok;
  assign underflow = Fifo_rd && empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_count = count;
    if (wr_ok && !rd_ok)      next_count = count + (AW+1)'(1);
    else if (rd_ok && !wr_ok) next_count = count - (AW+1)'(1);

    state_d = state_q;
    if (state_q == RUN && next_count >= HIGH_C)        state_d = PAUSED;
    else if (state_q == PAUSED && next_count <= LOW_C) state_d = RUN;
  end

  fifo_mem #(
    .BITNUMBER (BITNUMBER),
    .LENGTH    (LENGTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (Fifo_Data_in),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (Fifo_Data_out)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
      state_q   <= RUN;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count     <= next_count;
      valid_out <= rd_ok;
      error     <= error | overflow | underflow;
      state_q   <= state_d;
    end
  end

`ifdef FIFO_OCCUPANCY_EN
  assign occupancy = count;
`endif

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Self-checking bench for fifo_flow_ctrl: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_fifo_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_wr, fifo_rd;
  logic [7:0] din, dout;
  logic       valid_out, pause, empty, full, error;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus the externally visible flags.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_valid, m_pause, m_err;

  always #5 clk = ~clk;

  fifo_flow_ctrl #(
    .BITNUMBER (8),
    .LENGTH    (8),
    .HIGH_TH   (6),
    .LOW_TH    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Fifo_wr       (fifo_wr),
    .Fifo_rd       (fifo_rd),
    .Fifo_Data_in  (din),
    .Fifo_Data_out (dout),
    .valid_out     (valid_out),
    .pause         (pause),
    .empty         (empty),
    .full          (full),
    .error         (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},  32'(dout),      32'(m_dout));
    check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
    check({tag, ".pause"}, 32'(pause),     32'(m_pause));
    check({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
    check({tag, ".full"},  32'(full),      32'(q.size() == 8));
    check({tag, ".error"}, 32'(error),     32'(m_err));
  endtask

  task automatic model_clear();
    q.delete();
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_pause = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic rd, input logic [7:0] d);
    int  n_before;
    logic rd_acc, wr_acc;
    n_before = q.size();
    rd_acc   = rd && (n_before > 0);
    wr_acc   = wr && ((n_before < 8) || rd_acc);
    if ((wr && n_before == 8 && !rd_acc) || (rd && n_before == 0)) m_err = 1'b1;
    m_valid = rd_acc;
    if (rd_acc) m_dout = q.pop_front();
    if (wr_acc) q.push_back(d);
    if (!m_pause && q.size() >= 6)     m_pause = 1'b1;
    else if (m_pause && q.size() <= 2) m_pause = 1'b0;
  endtask

  task automatic step(input logic wr, input logic rd, input logic [7:0] d, input string tag);
    fifo_wr = wr;
    fifo_rd = rd;
    din     = d;
    @(posedge clk);
    model_edge(wr, rd, d);
    #1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    check_all(tag);
  endtask

  // Reset is raised between edges and checked before any further clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b;
    bit         fill;
    reset   = 1'b1;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    din     = 8'h00;
    model_clear();
    #1;
    check_all("por");
    @(negedge clk);
    reset = 1'b0;

    // Basic write then read: 1-cycle read latency, in-order data.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h0A + 8'(i), "t1_wr");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00, "t1_rd");
      check("t1_rd.lit", 32'(dout), 32'(8'h0A + 8'(i)));
    end
    step(1'b0, 1'b0, 8'h00, "t1_idle");
    check("t1_end.empty", 32'(empty), 32'(1));

    // Pause hysteresis: rise on 6th write, fall when count drops to 2.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 8'h40 + 8'(i), "t2_wr");
      check("t2_wr.pause_lit", 32'(pause), 32'(i == 5));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00, "t2_rd");
      check("t2_rd.pause_lit", 32'(pause), 32'(i < 3));
    end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 8'h00, "t2_drain");

    // Fill to full, overflow write is dropped, then read back originals.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), "t3_wr");
    check("t3.full_lit", 32'(full), 32'(1));
    step(1'b1, 1'b0, 8'hFF, "t3_ovf");
    check("t3_ovf.error_lit", 32'(error), 32'(1));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, "t3_rd");
      check("t3_rd.lit", 32'(dout), 32'(8'h10 + 8'(i)));
    end

    // Simultaneous read/write while full; wrap-around order preserved.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h20 + 8'(i), "t4_wr");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 8'h30 + 8'(i), "t4_rw");
      check("t4_rw.lit", 32'(dout), 32'(8'h20 + 8'(i)));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 8'h00, "t4_rd");
      exp_b = (i < 5) ? 8'h23 + 8'(i) : 8'h30 + 8'(i - 5);
      check("t4_rd.lit", 32'(dout), 32'(exp_b));
    end
    do_reset("t4_rst");

    // Read+write on empty: write lands, read is an underflow.
    step(1'b1, 1'b1, 8'h0F, "t5_rw");
    check("t5.valid_lit", 32'(valid_out), 32'(0));
    check("t5.error_lit", 32'(error), 32'(1));
    step(1'b0, 1'b1, 8'h00, "t5_rd");
    check("t5_rd.lit", 32'(dout), 32'(8'h0F));
    do_reset("t5_rst");

    // Async reset mid-stream with five words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), "t6_wr");
    do_reset("t6_rst");
    check("t6_rst.dout_lit", 32'(dout), 32'(0));
    step(1'b1, 1'b0, 8'h55, "t6_post_wr");
    step(1'b0, 1'b1, 8'h00, "t6_post_rd");
    check("t6_post.lit", 32'(dout), 32'(8'h55));

    // Random traffic with alternating fill/drain bias and occasional resets.
    fill = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) fill = ~fill;
      if ($urandom_range(399) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step($urandom_range(99) < (fill ? 75 : 30),
             $urandom_range(99) < (fill ? 30 : 75),
             8'($urandom), "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
